// File: rtl/ddr3_wr_packer.sv
// Packs a narrow beat stream into DDR3-width words, buffers them in a show-ahead
// FIFO and hands full write bursts to the DDR3 burst controller.
module ddr3_wr_packer #(
   parameter int unsigned DATA_WD         = 16,
   parameter int unsigned DQ_WIDTH        = 16,
   parameter int unsigned BEATS_PER_BURST = 16,
   parameter int unsigned FIFO_DEPTH      = 64
) (
   input  logic                          clk_ref,
   input  logic                          rst_n,
   input  logic                          frame_start,
   input  logic                          flush,
   input  logic                          din_valid,
   input  logic [DATA_WD-1:0]            din,
   output logic                          din_ready,
   output logic                          ddr3_wr_req,
   input  logic                          ddr3_wr_ack,
   output logic                          ddr3_wr_load,
   output logic [8*DQ_WIDTH-1:0]         ddr3_din,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          ack_err
);

   localparam int unsigned WORD_W = 8 * DQ_WIDTH;
   localparam int unsigned PACK   = WORD_W / DATA_WD;
   localparam int unsigned LANE_W = $clog2(PACK);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
   localparam int unsigned BCNT_W = $clog2(BEATS_PER_BURST + 1);

   typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                din_ready_q, din_ready_d;
   logic                wr_req_q, wr_req_d;
   logic                wr_load_q, wr_load_d;
   logic                ack_err_q, ack_err_d;
   logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];

   logic                accept, in_burst, pop, push, completes, do_flush;
   logic [LANE_W-1:0]   lane_base;
   logic [WORD_W-1:0]   word_base, word_new;
   logic [PTR_W-1:0]    wr_base, rd_base;
   logic [LVL_W-1:0]    lvl_base;
   logic [BCNT_W-1:0]   cnt_next;

   // Datapath and burst FSM next-state; frame_start rebases everything to empty first
   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      lane_d      = lane_q;
      word_d      = word_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      ack_err_d   = ack_err_q;
      cnt_next    = '0;

      lane_base   = frame_start ? '0 : lane_q;
      word_base   = frame_start ? '0 : word_q;
      wr_base     = frame_start ? '0 : wr_ptr_q;
      rd_base     = frame_start ? '0 : rd_ptr_q;
      lvl_base    = frame_start ? '0 : level_q;

      accept      = din_valid & din_ready_q;
      in_burst    = (state_q == REQ) || (state_q == BURST);
      pop         = ddr3_wr_ack & ~frame_start & in_burst & (level_q != '0);
      ack_err_d   = ack_err_q | (ddr3_wr_ack & ~frame_start & (~in_burst | (level_q == '0)));

      word_new    = word_base;
      if (accept) begin
         word_new[DATA_WD*32'(lane_base) +: DATA_WD] = din;
      end
      completes   = accept && (lane_base == LANE_W'(PACK - 1));
      // Unfilled lanes are already zero because the accumulator clears on every push
      do_flush    = flush & ~frame_start & (accept | (lane_base != '0))
                    & ((lvl_base < LVL_W'(FIFO_DEPTH)) | pop);
      push        = completes | do_flush;

      if (push) begin
         word_d   = '0;
         lane_d   = '0;
         wr_ptr_d = wr_base + PTR_W'(1);
      end else begin
         word_d   = word_new;
         lane_d   = lane_base + LANE_W'(accept);
         wr_ptr_d = wr_base;
      end
      rd_ptr_d    = rd_base + PTR_W'(pop);
      level_d     = lvl_base + LVL_W'(push) - LVL_W'(pop);

      if (frame_start) begin
         state_d = IDLE;
         bcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (level_d >= LVL_W'(BEATS_PER_BURST)) state_d = REQ;
            end
            REQ, BURST: begin
               cnt_next = ((state_q == REQ) ? '0 : bcnt_q) + BCNT_W'(1);
               if (pop) begin
                  if (cnt_next == BCNT_W'(BEATS_PER_BURST)) begin
                     state_d = IDLE;
                     bcnt_d  = '0;
                  end else begin
                     state_d = BURST;
                     bcnt_d  = cnt_next;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      wr_req_d    = (state_d == REQ);
      wr_load_d   = frame_start;
      din_ready_d = (level_d < LVL_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk_ref) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bcnt_q      <= '0;
         lane_q      <= '0;
         word_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         din_ready_q <= 1'b0;
         wr_req_q    <= 1'b0;
         wr_load_q   <= 1'b0;
         ack_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         din_ready_q <= din_ready_d;
         wr_req_q    <= wr_req_d;
         wr_load_q   <= wr_load_d;
         ack_err_q   <= ack_err_d;
      end
   end

   // FIFO storage; contents are only observable through a valid level
   always_ff @(posedge clk_ref) begin
      if (push) mem_q[wr_base] <= word_new;
   end

   assign ddr3_din     = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign din_ready    = din_ready_q;
   assign ddr3_wr_req  = wr_req_q;
   assign ddr3_wr_load = wr_load_q;
   assign fifo_level   = level_q;
   assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_ddr3_wr_packer.sv
// Bench for ddr3_wr_packer: queue-based reference model compared every cycle,
// directed scenarios with literal checks, then a randomized soak.
module tb_ddr3_wr_packer;

   localparam int unsigned PACK  = 8;
   localparam int unsigned BPB   = 16;
   localparam int unsigned DEPTH = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         frame_start, flush, din_valid, ddr3_wr_ack;
   logic [15:0]  din;
   logic         din_ready, ddr3_wr_req, ddr3_wr_load, ack_err;
   logic [127:0] ddr3_din;
   logic [6:0]   fifo_level;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;
   bit stalled = 1'b0;

   ddr3_wr_packer dut (
      .clk_ref     (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .flush       (flush),
      .din_valid   (din_valid),
      .din         (din),
      .din_ready   (din_ready),
      .ddr3_wr_req (ddr3_wr_req),
      .ddr3_wr_ack (ddr3_wr_ack),
      .ddr3_wr_load(ddr3_wr_load),
      .ddr3_din    (ddr3_din),
      .fifo_level  (fifo_level),
      .ack_err     (ack_err)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [127:0] mq[$];
   logic [15:0]  part[$];
   int           m_left = 0;
   bit           m_req = 0, m_load = 0, m_err = 0, m_ready = 0;
   bit           m_pop, was_idle;

   function automatic logic [127:0] pack_part();
      logic [127:0] w = '0;
      for (int i = 0; i < part.size(); i++) w[i*16 +: 16] = part[i];
      return w;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      started = 1'b1;
      if (!rst_n) begin
         mq.delete(); part.delete();
         m_left = 0; m_req = 0; m_load = 0; m_err = 0; m_ready = 0;
      end else begin
         m_pop    = 0;
         was_idle = (m_left == 0);
         if (frame_start) begin
            mq.delete(); part.delete();
            m_left = 0; m_req = 0;
         end else if (ddr3_wr_ack) begin
            if (m_left > 0 && mq.size() > 0) begin
               void'(mq.pop_front());
               m_pop = 1;
            end else begin
               m_err = 1;
            end
         end
         if (din_valid && m_ready) part.push_back(din);
         if (part.size() == PACK) begin
            mq.push_back(pack_part());
            part.delete();
         end else if (flush && !frame_start && part.size() > 0 && mq.size() < DEPTH) begin
            mq.push_back(pack_part());
            part.delete();
         end
         if (!frame_start) begin
            if (was_idle) begin
               if (mq.size() >= BPB) begin
                  m_left = BPB;
                  m_req  = 1;
               end
            end else if (m_pop) begin
               m_left--;
               m_req = 0;
            end
         end
         m_load  = frame_start;
         m_ready = (mq.size() < DEPTH);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("din_ready", din_ready, m_ready);
         chk("wr_req", ddr3_wr_req, m_req);
         chk("wr_load", ddr3_wr_load, m_load);
         chk("ack_err", ack_err, m_err);
         chk("fifo_level", fifo_level, 128'(mq.size()));
         chk("ddr3_din", ddr3_din, (mq.size() != 0) ? mq[0] : 128'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_beat(input logic [15:0] v);
      bit ok;
      int n = 0;
      din_valid = 1'b1;
      din       = v;
      do begin
         ok = din_ready;
         if (!ok) stalled = 1'b1;
         tick();
         n++;
      end while (!ok && n < 1000);
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL send_beat: got no din_ready expected acceptance within 1000 cycles");
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!ddr3_wr_req && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (!ddr3_wr_req) begin
         n_fail++;
         $display("FAIL wait_req: got wr_req=0 expected 1 within 2000 cycles");
      end
   endtask

   task automatic ack_bursts(input int nb);
      for (int b = 0; b < nb; b++) begin
         wait_req();
         repeat (3) @(negedge clk);
         ddr3_wr_ack = 1'b1;
         repeat (BPB) @(negedge clk);
         ddr3_wr_ack = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; flush = 1'b0;
      din_valid = 1'b0; din = '0; ddr3_wr_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_req", ddr3_wr_req, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", din_ready, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_before_release_edge", din_ready, 0);
      @(negedge clk);
      chk("ready_after_release", din_ready, 1);

      // 128 beats -> 16 words, request right after the last beat
      for (int i = 0; i < 128; i++) begin
         din_valid = 1'b1; din = 16'(i);
         tick();
      end
      din_valid = 1'b0;
      @(negedge clk);
      chk("lat_wr_req", ddr3_wr_req, 1);
      chk("word0", ddr3_din, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      chk("level16", fifo_level, 16);
      ddr3_wr_ack = 1'b1;
      repeat (BPB) @(negedge clk);
      ddr3_wr_ack = 1'b0;
      chk("drained_level", fifo_level, 0);
      chk("drained_req", ddr3_wr_req, 0);

      // Flush of a partial word, then a no-op flush
      din_valid = 1'b1; din = 16'hA; tick();
      din = 16'hB; tick();
      din = 16'hC; tick();
      din_valid = 1'b0; flush = 1'b1; tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_level", fifo_level, 1);
      chk("flush_word", ddr3_din, 128'h0000_000C_000B_000A);
      flush = 1'b1; tick(); flush = 1'b0;
      @(negedge clk);
      chk("flush_noop_level", fifo_level, 1);

      // Spurious ack while idle with three words stored
      for (int i = 0; i < 16; i++) begin
         din_valid = 1'b1; din = 16'(100 + i); tick();
      end
      din_valid = 1'b0;
      tick();
      ddr3_wr_ack = 1'b1; tick(); ddr3_wr_ack = 1'b0;
      @(negedge clk);
      chk("spurious_level", fifo_level, 3);
      chk("spurious_err", ack_err, 1);

      // frame_start after five acks of a burst, with a same-cycle beat
      for (int i = 0; i < 104; i++) begin
         din_valid = 1'b1; din = 16'(i); tick();
      end
      din_valid = 1'b0;
      wait_req();
      ddr3_wr_ack = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      frame_start = 1'b1; din_valid = 1'b1; din = 16'h55;
      tick();
      frame_start = 1'b0; ddr3_wr_ack = 1'b0; din_valid = 1'b0;
      @(negedge clk);
      chk("fs_wr_req", ddr3_wr_req, 0);
      chk("fs_level", fifo_level, 0);
      chk("fs_load", ddr3_wr_load, 1);
      @(negedge clk);
      chk("fs_load_once", ddr3_wr_load, 0);
      for (int i = 1; i < 8; i++) begin
         din_valid = 1'b1; din = 16'(i); tick();
      end
      din_valid = 1'b0;
      @(negedge clk);
      chk("fs_lane0_word", ddr3_din, 128'h0007_0006_0005_0004_0003_0002_0001_0055);
      chk("fs_word_level", fifo_level, 1);

      // Reset clears the sticky error
      rst_n = 1'b0; tick(); tick();
      rst_n = 1'b1; tick(); tick();
      @(negedge clk);
      chk("err_cleared", ack_err, 0);

      // Back-to-back bursts with a 3-cycle ack delay
      stalled = 1'b0;
      fork
         begin
            for (int i = 0; i < 256; i++) send_beat(16'(i * 3));
            din_valid = 1'b0;
         end
         ack_bursts(2);
      join
      @(negedge clk);
      chk("b2b_no_stall", stalled, 0);
      chk("b2b_ack_err", ack_err, 0);
      chk("b2b_level", fifo_level, 0);

      // Fill to full with no acks, then release one burst
      for (int i = 0; i < 512; i++) send_beat(16'(i) ^ 16'h5A5A);
      din_valid = 1'b1; din = 16'hBEEF;
      repeat (5) tick();
      @(negedge clk);
      chk("full_ready", din_ready, 0);
      chk("full_level", fifo_level, 64);
      din_valid = 1'b0;
      wait_req();
      ddr3_wr_ack = 1'b1;
      repeat (BPB) @(negedge clk);
      ddr3_wr_ack = 1'b0;
      chk("after_burst_ready", din_ready, 1);
      chk("after_burst_level", fifo_level, 48);

      // Randomized soak
      for (int c = 0; c < 3000; c++) begin
         tick();
         din_valid   = ($urandom_range(0, 9) < 7);
         din         = 16'($urandom);
         ddr3_wr_ack = ($urandom_range(0, 9) < 4);
         flush       = ($urandom_range(0, 49) == 0);
         frame_start = ($urandom_range(0, 199) == 0);
      end
      tick();
      din_valid = 1'b0; ddr3_wr_ack = 1'b0; flush = 1'b0; frame_start = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
